// File: rtl/mpdmac_cfg.sv
// mpdmac_cfg: APB register block and start/busy sequencer for the matrix DMA engine.
//
// Ports
//   clk, rst                      clock, synchronous active-high reset
//   psel_i, penable_i, paddr_i,
//   pwrite_i, pwdata_i            APB slave request (12-bit byte address)
//   pready_o, prdata_o, pslverr_o APB response, zero wait states (valid in access phase)
//   src_addr_o, dst_addr_o,
//   mat_width_o                   transfer configuration, straight from the registers
//   start_o                       high while the sequencer is in START
//   done_i                        engine idle flag (high when idle)
//   irq_o                         level completion interrupt
//
// Build option: define MPDMAC_CFG_IRQ_EN to include IRQ_EN/IRQ_STAT and irq_o.
// Without it irq_o is tied low and 0x114/0x118 decode as unmapped.
module mpdmac_cfg (
    input  logic        clk,
    input  logic        rst,
    input  logic        psel_i,
    input  logic        penable_i,
    input  logic [11:0] paddr_i,
    input  logic        pwrite_i,
    input  logic [31:0] pwdata_i,
    output logic        pready_o,
    output logic [31:0] prdata_o,
    output logic        pslverr_o,
    output logic [31:0] src_addr_o,
    output logic [31:0] dst_addr_o,
    output logic [5:0]  mat_width_o,
    output logic        start_o,
    input  logic        done_i,
    output logic        irq_o
);

    localparam logic [11:0] A_VERSION   = 12'h000;
    localparam logic [11:0] A_SRC       = 12'h100;
    localparam logic [11:0] A_DST       = 12'h104;
    localparam logic [11:0] A_MAT_WIDTH = 12'h108;
    localparam logic [11:0] A_CMD       = 12'h10C;
    localparam logic [11:0] A_STATUS    = 12'h110;
    localparam logic [11:0] A_IRQ_EN    = 12'h114;
    localparam logic [11:0] A_IRQ_STAT  = 12'h118;
    localparam logic [11:0] A_DONE_CNT  = 12'h11C;
    localparam logic [31:0] VERSION     = 32'h0001_2024;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_BUSY  = 2'd2
    } state_t;

    state_t      state, state_next;
    logic [31:0] src_q, dst_q;
    logic [5:0]  width_q;
    logic [15:0] done_cnt;
    logic        err_q;

    logic        access, busy, width_ok;
    logic [31:0] rdata;
    logic        slverr, we_src, we_dst, we_width, we_irq_en, w1c_irq;
    logic        err_set, err_clr, complete;

    assign access   = psel_i & penable_i;
    assign busy     = (state != ST_IDLE);
    // Engine supports even widths 2..60 only.
    assign width_ok = ~width_q[0] && (width_q >= 6'd2) && (width_q <= 6'd60);

`ifdef MPDMAC_CFG_IRQ_EN
    logic irq_en_q, irq_stat_q;
`endif

    // Sequencer next state and APB access decode.
    always_comb begin
        state_next = state;
        rdata      = '0;
        slverr     = 1'b0;
        we_src     = 1'b0;
        we_dst     = 1'b0;
        we_width   = 1'b0;
        we_irq_en  = 1'b0;
        w1c_irq    = 1'b0;
        err_set    = 1'b0;
        err_clr    = 1'b0;
        complete   = 1'b0;

        case (state)
            ST_START: if (!done_i) state_next = ST_BUSY;
            ST_BUSY: begin
                if (done_i) begin
                    state_next = ST_IDLE;
                    complete   = 1'b1;
                end
            end
            default: ;
        endcase

        if (access) begin
            case (paddr_i)
                A_VERSION: begin
                    if (pwrite_i) slverr = 1'b1;
                    else          rdata  = VERSION;
                end
                A_SRC: begin
                    if (!pwrite_i)  rdata  = src_q;
                    else if (busy)  slverr = 1'b1;
                    else            we_src = 1'b1;
                end
                A_DST: begin
                    if (!pwrite_i)  rdata  = dst_q;
                    else if (busy)  slverr = 1'b1;
                    else            we_dst = 1'b1;
                end
                A_MAT_WIDTH: begin
                    if (!pwrite_i)  rdata    = {26'd0, width_q};
                    else if (busy)  slverr   = 1'b1;
                    else            we_width = 1'b1;
                end
                A_CMD: begin
                    if (!pwrite_i) begin
                        slverr = 1'b1;
                    end else if (pwdata_i[0]) begin
                        // Sequencer is IDLE whenever a start is accepted, so this
                        // never collides with the state case above.
                        if (busy) begin
                            slverr = 1'b1;
                        end else if (!width_ok) begin
                            slverr  = 1'b1;
                            err_set = 1'b1;
                        end else begin
                            state_next = ST_START;
                            err_clr    = 1'b1;
                        end
                    end
                end
                A_STATUS: begin
                    if (pwrite_i) slverr = 1'b1;
                    else          rdata  = {29'd0, err_q, busy, done_i};
                end
`ifdef MPDMAC_CFG_IRQ_EN
                A_IRQ_EN: begin
                    if (pwrite_i) we_irq_en = 1'b1;
                    else          rdata     = {31'd0, irq_en_q};
                end
                A_IRQ_STAT: begin
                    if (pwrite_i) w1c_irq = pwdata_i[0];
                    else          rdata   = {31'd0, irq_stat_q};
                end
`endif
                A_DONE_CNT: begin
                    if (pwrite_i) slverr = 1'b1;
                    else          rdata  = {16'd0, done_cnt};
                end
                default: slverr = 1'b1;
            endcase
        end
    end

    // Sequencer state register.
    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_next;
    end

    // Configuration, error and completion-count registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            src_q    <= '0;
            dst_q    <= '0;
            width_q  <= '0;
            err_q    <= 1'b0;
            done_cnt <= '0;
        end else begin
            if (we_src)   src_q   <= pwdata_i;
            if (we_dst)   dst_q   <= pwdata_i;
            if (we_width) width_q <= pwdata_i[5:0];
            if (err_set)      err_q <= 1'b1;
            else if (err_clr) err_q <= 1'b0;
            if (complete) done_cnt <= done_cnt + 16'd1;
        end
    end

`ifdef MPDMAC_CFG_IRQ_EN
    // Interrupt enable and sticky status; a completion beats a same-cycle W1C.
    always_ff @(posedge clk) begin
        if (rst) begin
            irq_en_q   <= 1'b0;
            irq_stat_q <= 1'b0;
        end else begin
            if (we_irq_en) irq_en_q <= pwdata_i[0];
            if (complete)     irq_stat_q <= 1'b1;
            else if (w1c_irq) irq_stat_q <= 1'b0;
        end
    end
    assign irq_o = irq_stat_q & irq_en_q & ~rst;
`else
    assign irq_o = 1'b0;
`endif

    // Response and strobe outputs are held quiet while reset is asserted.
    assign pready_o    = access & ~rst;
    assign pslverr_o   = slverr & ~rst;
    assign prdata_o    = rst ? 32'd0 : rdata;
    assign start_o     = (state == ST_START) & ~rst;
    assign src_addr_o  = src_q;
    assign dst_addr_o  = dst_q;
    assign mat_width_o = width_q;

endmodule

// File: doc/mpdmac_cfg.md
MPDMAC_CFG -- requirements
Module: mpdmac_cfg

Interface
REQ-001 SHALL have one clock and a synchronous, active-high reset: clk  in  1  clock, all logic on rising edge; rst  in  1  synchronous active-high reset.
REQ-002 SHALL have these APB slave ports: psel_i in 1; penable_i in 1; paddr_i in 12 (byte address); pwrite_i in 1; pwdata_i in 32; pready_o out 1; prdata_o out 32; pslverr_o out 1.
REQ-003 SHALL have these engine-side ports: src_addr_o out 32; dst_addr_o out 32; mat_width_o out 6; start_o out 1; done_i in 1 (engine idle flag, high when idle).
REQ-004 SHALL have irq_o out 1, level interrupt.

Function
REQ-005 Register map SHALL be: 0x000 VERSION RO 0x0001_2024; 0x100 SRC_ADDR RW; 0x104 DST_ADDR RW; 0x108 MAT_WIDTH RW [5:0]; 0x10C CMD WO bit0=START; 0x110 STATUS RO; 0x114 IRQ_EN RW bit0; 0x118 IRQ_STAT W1C bit0; 0x11C DONE_CNT RO [15:0].
REQ-006 STATUS SHALL be: bit0=engine idle (done_i); bit1=busy (sequencer not IDLE); bit2=ERR (sticky, cleared by a legal START).
REQ-007 APB access SHALL complete with zero wait states; pready_o=1 only in the access phase (psel_i&penable_i); prdata_o is valid in that cycle and 0 otherwise.
REQ-008 Register writes SHALL take effect on the clock edge that ends the access phase; unused bits read 0.
REQ-009 Unmapped address, write to an RO register, or read of CMD SHALL assert pslverr_o in the access phase with no state change; such reads return 0.
REQ-010 Writes to SRC_ADDR, DST_ADDR or MAT_WIDTH while busy SHALL assert pslverr_o and leave the value unchanged.
REQ-011 src_addr_o, dst_addr_o and mat_width_o SHALL drive the register contents directly.
REQ-012 The sequencer SHALL have states IDLE, START and BUSY.
REQ-013 A CMD write with bit0=1 in IDLE, with MAT_WIDTH even and in 2..60, SHALL move the sequencer to START and clear ERR.
REQ-014 A START request with an illegal width SHALL assert pslverr_o, set ERR and stay in IDLE.
REQ-015 A START request while in START or BUSY SHALL assert pslverr_o and be ignored; ERR is not set.
REQ-016 start_o SHALL be 1 exactly while in START.
REQ-017 START SHALL move to BUSY on the first cycle done_i=0.
REQ-018 BUSY SHALL move to IDLE on the first cycle done_i=1.
REQ-019 On the BUSY->IDLE transition, the block SHALL set IRQ_STAT bit0 and increment DONE_CNT, wrapping 0xFFFF->0x0000.
REQ-020 irq_o SHALL equal IRQ_STAT bit0 & IRQ_EN bit0.
REQ-021 If a W1C of IRQ_STAT and a completion occur in the same cycle, set SHALL win.
REQ-022 CMD bit0=0 writes SHALL have no effect and no error.

Reset
REQ-023 On rst=1 at a clock edge, every register SHALL clear to 0 (SRC, DST, MAT_WIDTH, IRQ_EN, IRQ_STAT, DONE_CNT, ERR) and the sequencer SHALL go to IDLE.
REQ-024 During reset, outputs SHALL be: start_o=0, irq_o=0, pready_o=0, pslverr_o=0, prdata_o=0.
REQ-025 Reset asserted mid-operation SHALL abandon the sequence; the sequencer restarts from IDLE regardless of done_i.

Configuration
REQ-026 With macro MPDMAC_CFG_IRQ_EN defined, IRQ_EN, IRQ_STAT and irq_o SHALL behave per REQ-019..REQ-021.
REQ-027 Without MPDMAC_CFG_IRQ_EN, irq_o SHALL be tied 0, addresses 0x114 and 0x118 SHALL be unmapped (pslverr_o per REQ-009), and DONE_CNT SHALL still operate.

Verification
REQ-028 Bench SHALL write SRC=0x1000, DST=0x2000, MAT_WIDTH=4, then CMD=1 with done_i=1 -> start_o high next cycle; done_i drops 2 cycles later -> start_o low the following cycle.
REQ-029 Bench SHALL, after REQ-028, raise done_i -> STATUS=0x1, DONE_CNT=1, irq_o=1 if IRQ_EN=1; W1C 0x118 -> irq_o=0.
REQ-030 Bench SHALL write MAT_WIDTH=5 then CMD=1 -> pslverr_o=1, start_o stays 0, STATUS bit2=1; MAT_WIDTH=62 -> same result.
REQ-031 Bench SHALL, while BUSY, write SRC=0xDEAD and CMD=1 -> both pslverr_o=1, SRC still 0x1000, no second start_o pulse.
REQ-032 Bench SHALL preset DONE_CNT=0xFFFF via 65535 completions (or force) and run one more -> DONE_CNT=0x0000; W1C in the completion cycle -> IRQ_STAT stays 1.
REQ-033 Bench SHALL assert rst while in START -> next cycle start_o=0, all registers 0, STATUS=done_i.
